// File: rtl/npxl_empfaenger_if.sv
// NeoPixel receiver bus: serial line in, decoded words and status strobes out.
interface npxl_empfaenger_if;
  logic        i_npxl_data;
  logic [23:0] o_color_data;
  logic [7:0]  o_led_index;
  logic        o_valid;
  logic        o_frame_done;
  logic [7:0]  o_led_count;
  logic        o_err;
  logic [1:0]  o_err_code;

  // Receiver side: samples the line, drives the decoded results.
  modport slave (
    input  i_npxl_data,
    output o_color_data, o_led_index, o_valid, o_frame_done,
    output o_led_count, o_err, o_err_code
  );

  // Line driver / observer side.
  modport master (
    output i_npxl_data,
    input  o_color_data, o_led_index, o_valid, o_frame_done,
    input  o_led_count, o_err, o_err_code
  );
endinterface

// File: rtl/npxl_empfaenger.sv
// WS2812/NeoPixel bitstream receiver: pulse-width bit decoding, 24-bit word
// assembly (MSB first), latch-gap frame detection and protocol error reporting.
module npxl_empfaenger #(
  parameter int unsigned LEDS       = 20,
  parameter int unsigned T_MIN_HIGH = 8,
  parameter int unsigned T_THRESH   = 30,
  parameter int unsigned T_MAX_HIGH = 56,
  parameter int unsigned T_RESET    = 2400
) (
  input  logic               i_clk,
  input  logic               i_rst,
  npxl_empfaenger_if.slave   bus
);
  localparam int unsigned CW = 12;
  localparam int unsigned BW = 5;
  localparam int unsigned LW = 8;
  localparam int unsigned DW = 24;

  typedef enum logic [1:0] {SYNC, SPACE, MARK} state_t;

  state_t          state, state_nxt;
  logic            sync1, s;
  logic [CW-1:0]   pc, pc_nxt, lc, lc_nxt, pc_inc, lc_inc;
  logic [BW-1:0]   bc, bc_nxt;
  logic [LW-1:0]   lc_led, lc_led_nxt;
  logic [DW-1:0]   sr, sr_nxt, word;
  logic            bit_val;

  logic [DW-1:0]   color_q, color_nxt;
  logic [LW-1:0]   index_q, index_nxt;
  logic [LW-1:0]   count_q, count_nxt;
  logic [1:0]      code_q, code_nxt;
  logic            valid_q, valid_nxt, done_q, done_nxt, err_q, err_nxt;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= bus.i_npxl_data;
      s     <= sync1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= SYNC;
      pc      <= '0;
      lc      <= '0;
      bc      <= '0;
      lc_led  <= '0;
      sr      <= '0;
      color_q <= '0;
      index_q <= '0;
      count_q <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      lc      <= lc_nxt;
      bc      <= bc_nxt;
      lc_led  <= lc_led_nxt;
      sr      <= sr_nxt;
      color_q <= color_nxt;
      index_q <= index_nxt;
      count_q <= count_nxt;
      code_q  <= code_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state, counter and strobe logic.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    lc_nxt     = lc;
    bc_nxt     = bc;
    lc_led_nxt = lc_led;
    sr_nxt     = sr;
    color_nxt  = color_q;
    index_nxt  = index_q;
    count_nxt  = count_q;
    code_nxt   = code_q;
    valid_nxt  = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;

    bit_val = (pc >= CW'(T_THRESH));
    word    = {sr[DW-2:0], bit_val};
    lc_inc  = (lc >= CW'(T_RESET)) ? CW'(T_RESET) : lc + CW'(1);
    pc_inc  = (pc == '1) ? pc : pc + CW'(1);

    case (state)
      // Wait for a full latch gap before trusting the line.
      SYNC: begin
        if (s) begin
          lc_nxt = '0;
        end else begin
          lc_nxt = lc_inc;
          if (lc_inc == CW'(T_RESET)) begin
            state_nxt  = SPACE;
            bc_nxt     = '0;
            lc_led_nxt = '0;
          end
        end
      end

      // Low time between pulses; the first arrival at T_RESET closes the frame.
      SPACE: begin
        if (s) begin
          state_nxt = MARK;
          pc_nxt    = CW'(1);
        end else begin
          lc_nxt = lc_inc;
          if ((lc < CW'(T_RESET)) && (lc_inc == CW'(T_RESET))) begin
            if (bc != '0) begin
              err_nxt  = 1'b1;
              code_nxt = 2'b11;
            end else if (lc_led != '0) begin
              done_nxt  = 1'b1;
              count_nxt = lc_led;
            end
            bc_nxt     = '0;
            lc_led_nxt = '0;
          end
        end
      end

      // High pulse: measure width, classify on the falling edge.
      MARK: begin
        if (s) begin
          pc_nxt = pc_inc;
          if (pc_inc > CW'(T_MAX_HIGH)) begin
            err_nxt   = 1'b1;
            code_nxt  = 2'b10;
            state_nxt = SYNC;
            lc_nxt    = '0;
          end
        end else if (pc < CW'(T_MIN_HIGH)) begin
          err_nxt   = 1'b1;
          code_nxt  = 2'b01;
          state_nxt = SYNC;
          lc_nxt    = CW'(1);
        end else begin
          sr_nxt    = word;
          state_nxt = SPACE;
          lc_nxt    = CW'(1);
          if (bc == BW'(DW - 1)) begin
            bc_nxt = '0;
            if (lc_led == LW'(LEDS)) begin
              err_nxt   = 1'b1;
              code_nxt  = 2'b11;
              state_nxt = SYNC;
            end else begin
              valid_nxt  = 1'b1;
              color_nxt  = word;
              index_nxt  = lc_led;
              lc_led_nxt = lc_led + LW'(1);
            end
          end else begin
            bc_nxt = bc + BW'(1);
          end
        end
      end

      default: state_nxt = SYNC;
    endcase
  end

  assign bus.o_color_data = color_q;
  assign bus.o_led_index  = index_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_frame_done = done_q;
  assign bus.o_led_count  = count_q;
  assign bus.o_err        = err_q;
  assign bus.o_err_code   = code_q;
endmodule
